// File: rtl/simd_div_multi.sv
// rtl/simd_div_multi.sv - multi-unit SIMD integer divider splitting an ELEN-bit word into elements
// Elements are dispatched in rounds of NR_UNITS serial dividers and packed back in place.

module serdiv #(
  parameter int ELEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_vld_i,
  output logic            in_rdy_o,
  input  logic [1:0]      opcode_i,
  input  logic [ELEN-1:0] op_a_i,
  input  logic [ELEN-1:0] op_b_i,
  output logic            out_vld_o,
  input  logic            out_rdy_i,
  output logic [ELEN-1:0] res_o
);

  localparam int CW = $clog2(ELEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sd_state_e;

  sd_state_e       state_q, state_d;
  logic [ELEN-1:0] rem_q, rem_d;
  logic [ELEN-1:0] quo_q, quo_d;
  logic [ELEN-1:0] div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rem_sel_q, rem_sel_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            zero_q, zero_d;

  logic            a_neg, b_neg;
  logic [ELEN:0]   shifted, diff;
  logic [ELEN-1:0] q_fix, r_fix;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    zero_d    = zero_q;
    a_neg     = opcode_i[0] & op_a_i[ELEN-1];
    b_neg     = opcode_i[0] & op_b_i[ELEN-1];
    shifted   = {rem_q, quo_q[ELEN-1]};
    diff      = shifted - {1'b0, div_q};
    case (state_q)
      S_IDLE: begin
        if (in_vld_i) begin
          rem_d     = '0;
          quo_d     = a_neg ? -op_a_i : op_a_i;
          div_d     = b_neg ? -op_b_i : op_b_i;
          cnt_d     = '0;
          rem_sel_d = opcode_i[1];
          negq_d    = a_neg ^ b_neg;
          negr_d    = a_neg;
          zero_d    = (op_b_i == '0);
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // Restoring division: one quotient bit per cycle, MSB first.
        if (shifted >= {1'b0, div_q}) begin
          rem_d = diff[ELEN-1:0];
          quo_d = {quo_q[ELEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[ELEN-1:0];
          quo_d = {quo_q[ELEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ELEN - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      zero_q    <= zero_d;
    end
  end

  // A zero divisor keeps the raw all-ones quotient; sign correction would corrupt it.
  assign q_fix     = zero_q ? '1 : (negq_q ? -quo_q : quo_q);
  assign r_fix     = negr_q ? -rem_q : rem_q;
  assign res_o     = rem_sel_q ? r_fix : q_fix;
  assign in_rdy_o  = (state_q == S_IDLE);
  assign out_vld_o = (state_q == S_DONE);

endmodule

module simd_div_multi #(
  parameter int ELEN     = 64,
  parameter int NR_UNITS = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ELEN-1:0]   operand_a_i,
  input  logic [ELEN-1:0]   operand_b_i,
  input  logic [2:0]        op_i,
  input  logic [1:0]        vew_i,
  input  logic [ELEN/8-1:0] be_i,
  input  logic [ELEN/8-1:0] mask_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic [ELEN-1:0]   result_o,
  output logic [ELEN/8-1:0] mask_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int NB = ELEN / 8;
  localparam int BW = $clog2(NB);
  localparam int LW = $clog2(ELEN);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic [ELEN-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]          op_q, op_d, vew_q, vew_d;
  logic [NB-1:0]       be_q, be_d, mask_q, mask_d;
  logic [7:0]          rnd_q, rnd_d;
  logic [NR_UNITS-1:0] issued_q, issued_d, ret_q, ret_d;

  logic [7:0]          w_bits, nelem, nrounds, last_rnd;
  logic                supported;
  logic [ELEN-1:0]     slot_mask;
  logic [NR_UNITS-1:0] sel, in_vld, in_rdy, out_vld, out_rdy;
  logic [7:0]          elem [NR_UNITS];
  logic [7:0]          bidx [NR_UNITS];
  logic [15:0]         off  [NR_UNITS];
  logic [ELEN-1:0]     u_a  [NR_UNITS];
  logic [ELEN-1:0]     u_b  [NR_UNITS];
  logic [ELEN-1:0]     u_res[NR_UNITS];

  function automatic logic [ELEN-1:0] ext(input logic [ELEN-1:0] v, input logic [7:0] w,
                                          input logic sgn);
    logic [ELEN-1:0] r;
    logic [7:0]      msb;
    msb = w - 8'd1;
    for (int i = 0; i < ELEN; i++) r[i] = (i < int'(w)) ? v[i] : (sgn & v[msb[LW-1:0]]);
    return r;
  endfunction

  always_comb begin
    w_bits    = 8'd8 << vew_q;
    supported = !(ELEN == 32 && vew_q == 2'd3);
    nelem     = supported ? 8'(ELEN >> (3 + vew_q)) : 8'd0;
    // An unsupported width still runs one (empty) round so the request reaches DONE.
    nrounds   = (nelem == 8'd0) ? 8'd1 : 8'((32'(nelem) + NR_UNITS - 1) / NR_UNITS);
    last_rnd  = nrounds - 8'd1;
    slot_mask = (32'(w_bits) >= ELEN) ? '1 : ((ELEN'(1) << w_bits) - ELEN'(1));
    for (int u = 0; u < NR_UNITS; u++) begin
      elem[u] = 8'(32'(rnd_q) * NR_UNITS + u);
      bidx[u] = elem[u] << vew_q;
      sel[u]  = (elem[u] < nelem) && (bidx[u] < 8'(NB)) && be_q[bidx[u][BW-1:0]];
      off[u]  = 16'(elem[u]) * 16'(w_bits);
      u_a[u]  = ext(a_q >> off[u], w_bits, op_q[0]);
      u_b[u]  = ext(b_q >> off[u], w_bits, op_q[0]);
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    vew_d    = vew_q;
    be_d     = be_q;
    mask_d   = mask_q;
    res_d    = res_q;
    rnd_d    = rnd_q;
    issued_d = issued_q;
    ret_d    = ret_q;
    in_vld   = '0;
    out_rdy  = '0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d      = operand_a_i;
          b_d      = operand_b_i;
          op_d     = (op_i < 3'd4) ? op_i[1:0] : 2'b00;
          vew_d    = vew_i;
          be_d     = be_i;
          mask_d   = mask_i;
          res_d    = '0;
          rnd_d    = '0;
          issued_d = '0;
          ret_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        for (int u = 0; u < NR_UNITS; u++) begin
          in_vld[u] = sel[u] && !issued_q[u];
          if (in_vld[u] && in_rdy[u]) issued_d[u] = 1'b1;
        end
        ret_d = '0;
        if (sel == '0) begin
          if (rnd_q == last_rnd) state_d = DONE;
          else                   rnd_d   = rnd_q + 8'd1;
        end else if ((sel & ~issued_d) == '0) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        for (int u = 0; u < NR_UNITS; u++) begin
          out_rdy[u] = issued_q[u] && !ret_q[u];
          if (out_rdy[u] && out_vld[u]) begin
            ret_d[u] = 1'b1;
            res_d    = (res_d & ~(slot_mask << off[u])) | ((u_res[u] & slot_mask) << off[u]);
          end
        end
        if ((issued_q & ~ret_d) == '0) begin
          issued_d = '0;
          ret_d    = '0;
          if (rnd_q == last_rnd) begin
            state_d = DONE;
          end else begin
            rnd_d   = rnd_q + 8'd1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      vew_q    <= '0;
      be_q     <= '0;
      mask_q   <= '0;
      res_q    <= '0;
      rnd_q    <= '0;
      issued_q <= '0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      vew_q    <= vew_d;
      be_q     <= be_d;
      mask_q   <= mask_d;
      res_q    <= res_d;
      rnd_q    <= rnd_d;
      issued_q <= issued_d;
      ret_q    <= ret_d;
    end
  end

  for (genvar g = 0; g < NR_UNITS; g++) begin : g_unit
    serdiv #(.ELEN(ELEN)) u_serdiv (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (flush_i),
      .in_vld_i  (in_vld[g]),
      .in_rdy_o  (in_rdy[g]),
      .opcode_i  (op_q),
      .op_a_i    (u_a[g]),
      .op_b_i    (u_b[g]),
      .out_vld_o (out_vld[g]),
      .out_rdy_i (out_rdy[g]),
      .res_o     (u_res[g])
    );
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = (state_q == DONE) ? res_q : '0;
  assign mask_o   = mask_q;

endmodule

// File: tb/tb_simd_div_multi.sv
// tb/tb_simd_div_multi.sv - randomized self-checking bench for simd_div_multi
// Expected results come from a per-element arithmetic model of RVV divide/remainder.

module tb_simd_div_multi;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] operand_a = '0, operand_b = '0;
  logic [2:0]  op = '0;
  logic [1:0]  vew = '0;
  logic [7:0]  be = '0, mask_in = '0;
  logic        valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
  logic        ready_o, valid_o;
  logic [63:0] result_o;
  logic [7:0]  mask_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simd_div_multi #(.ELEN(64), .NR_UNITS(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .operand_a_i (operand_a),
    .operand_b_i (operand_b),
    .op_i        (op),
    .vew_i       (vew),
    .be_i        (be),
    .mask_i      (mask_in),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .mask_o      (mask_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] opc, input logic [1:0] ew,
                                        input logic [7:0] ben);
    int          w, n;
    logic [1:0]  o;
    logic [63:0] m, ea, eb, q, r, val, res;
    longint      sa, sb;
    w   = 8 << ew;
    n   = 64 / w;
    o   = (opc < 3'd4) ? opc[1:0] : 2'b00;
    m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    res = '0;
    for (int k = 0; k < n; k++) begin
      if (ben[k * (w / 8)]) begin
        ea = (a >> (k * w)) & m;
        eb = (b >> (k * w)) & m;
        sa = longint'(ea << (64 - w)) >>> (64 - w);
        sb = longint'(eb << (64 - w)) >>> (64 - w);
        if (eb == 0) begin
          q = m;
          r = ea;
        end else if (o[0]) begin
          if (sb == -1) begin
            q = 64'(-sa);
            r = 64'd0;
          end else begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
          end
        end else begin
          q = ea / eb;
          r = ea % eb;
        end
        val = o[1] ? r : q;
        res = res | ((val & m) << (k * w));
      end
    end
    return res;
  endfunction

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] opc,
                      input logic [1:0] ew, input logic [7:0] ben, input logic [7:0] msk,
                      input bit fl);
    int t = 0;
    while (!ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) chk("ready_timeout", 64'(ready_o), 64'd1);
    operand_a = a;
    operand_b = b;
    op        = opc;
    vew       = ew;
    be        = ben;
    mask_in   = msk;
    valid_i   = 1'b1;
    flush_i   = fl;
    @(negedge clk);
    valid_i   = 1'b0;
    flush_i   = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int t = 0;
    while (!valid_o && t < 1500) begin
      @(negedge clk);
      t++;
    end
    ok = valid_o;
    if (!ok) chk("done_timeout", 64'(valid_o), 64'd1);
  endtask

  task automatic release_result(input int delay);
    repeat (delay) @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("valid_after_pop", 64'(valid_o), 64'd0);
    chk("ready_after_pop", 64'(ready_o), 64'd1);
  endtask

  task automatic run_req(input logic [63:0] a, input logic [63:0] b, input logic [2:0] opc,
                         input logic [1:0] ew, input logic [7:0] ben, input logic [7:0] msk,
                         input logic [63:0] exp, input int delay, input bit fl,
                         output logic [63:0] got);
    bit ok;
    send(a, b, opc, ew, ben, msk, fl);
    wait_done(ok);
    got = result_o;
    if (ok) begin
      chk("result", result_o, exp);
      chk("mask", 64'(mask_o), 64'(msk));
      chk("ready_busy", 64'(ready_o), 64'd0);
    end
    release_result(delay);
  endtask

  initial begin
    logic [63:0] got, a, b, exp;
    logic [2:0]  opc;
    logic [1:0]  ew;
    logic [7:0]  ben, msk;
    bit          ok;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_mask", 64'(mask_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    run_req(64'h6432_1E0A_0908_0706, 64'h0303_0303_0303_0303, 3'd0, 2'd0, 8'hFF, 8'hA5,
            64'h2110_0A03_0302_0202, 0, 1'b0, got);
    run_req(64'hFFFF_FFF9_0000_0064, 64'h0000_0002_FFFF_FFF7, 3'd1, 2'd2, 8'hFF, 8'h3C,
            64'hFFFF_FFFD_FFFF_FFF5, 1, 1'b0, got);
    run_req(64'hFFFF_FFF9_0000_0064, 64'h0000_0002_FFFF_FFF7, 3'd3, 2'd2, 8'hFF, 8'h11,
            64'hFFFF_FFFF_0000_0001, 2, 1'b0, got);
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'h0005_0007_0000_0003;
    run_req(a, b, 3'd0, 2'd1, 8'hFF, 8'h0F, model(a, b, 3'd0, 2'd1, 8'hFF), 0, 1'b0, got);
    chk("ew16_div0_quot", 64'(got[31:16]), 64'h0000_0000_0000_FFFF);
    run_req(a, b, 3'd2, 2'd1, 8'hFF, 8'hF0, model(a, b, 3'd2, 2'd1, 8'hFF), 0, 1'b0, got);
    chk("ew16_rem0_dividend", 64'(got[31:16]), 64'h0000_0000_0000_9ABC);
    run_req({8{8'h80}}, {8{8'hFF}}, 3'd1, 2'd0, 8'hFF, 8'h00, {8{8'h80}}, 0, 1'b0, got);
    run_req({8{8'h80}}, {8{8'hFF}}, 3'd3, 2'd0, 8'hFF, 8'h00, 64'd0, 0, 1'b0, got);
    run_req({8{8'h80}}, {8{8'hFF}}, 3'd1, 2'd0, 8'h0F, 8'h0F, 64'h0000_0000_8080_8080, 0, 1'b0, got);
    run_req(64'hDEAD_BEEF_0123_4567, 64'h1111_1111_1111_1111, 3'd6, 2'd3, 8'h00, 8'h77,
            64'd0, 0, 1'b0, got);
    // flush_i in IDLE must not block or disturb acceptance
    run_req(64'd1000, 64'd7, 3'd0, 2'd3, 8'hFF, 8'h01, 64'd142, 0, 1'b1, got);

    // flush mid-WAIT, then a partial request must show no stale slot data
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 3'd0, 2'd0, 8'hFF, 8'hFF, 1'b0);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_ready", 64'(ready_o), 64'd1);
    chk("flush_valid", 64'(valid_o), 64'd0);
    a = 64'h5555_5555_1234_5678;
    b = 64'h0202_0202_0303_0303;
    run_req(a, b, 3'd0, 2'd0, 8'h0F, 8'h5A, model(a, b, 3'd0, 2'd0, 8'h0F), 0, 1'b0, got);

    // result held stable while the consumer stalls
    a = 64'h0000_1234_0000_5678;
    b = 64'h0000_0011_0000_0022;
    exp = model(a, b, 3'd2, 2'd2, 8'hFF);
    send(a, b, 3'd2, 2'd2, 8'hFF, 8'hC3, 1'b0);
    wait_done(ok);
    for (int i = 0; i < 10 && ok; i++) begin
      chk("hold_result", result_o, exp);
      chk("hold_mask", 64'(mask_o), 64'hC3);
      chk("hold_ready", 64'(ready_o), 64'd0);
      chk("hold_valid", 64'(valid_o), 64'd1);
      @(negedge clk);
    end
    release_result(0);

    // flush together with ready_i in DONE
    send(64'd99, 64'd9, 3'd0, 2'd3, 8'hFF, 8'h01, 1'b0);
    wait_done(ok);
    flush_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    ready_i = 1'b0;
    chk("flush_done_valid", 64'(valid_o), 64'd0);
    chk("flush_done_ready", 64'(ready_o), 64'd1);

    // asynchronous reset while ISSUE is in progress
    send(64'h0F0F_0F0F_0F0F_0F0F, 64'h0505_0505_0505_0505, 3'd0, 2'd0, 8'hFF, 8'hEE, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_result", result_o, 64'd0);
    chk("mid_rst_mask", 64'(mask_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 50; it++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) if ($urandom_range(0, 5) == 0) b[k*8 +: 8] = 8'h00;
      if ($urandom_range(0, 7) == 0) begin
        a = {8{8'h80}};
        b = {8{8'hFF}};
      end
      opc = 3'($urandom_range(0, 7));
      ew  = 2'($urandom_range(0, 3));
      ben = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      msk = 8'($urandom);
      run_req(a, b, opc, ew, ben, msk, model(a, b, opc, ew, ben), $urandom_range(0, 3), 1'b0, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
